// File: rtl/ipv4_arp_pkg.sv
// Shared definitions for the IPv4 ARP learn path: FSM states, LUT write-data
// width and the binding drop filter.
package ipv4_arp_pkg;

  localparam int unsigned LUT_WR_DATA_W = 64;
  localparam int unsigned MAC_GROUP_BIT = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH_LO,
    ST_SEARCH_HI,
    ST_WRITE,
    ST_WAIT_ACK
  } learn_state_t;

  // Unspecified sender IP, group MAC or all-zero MAC are never learned
  function automatic logic learn_drop(input logic [31:0] ipv4, input logic [47:0] mac);
    return (ipv4 == 32'h0) || mac[MAC_GROUP_BIT] || (mac == 48'h0);
  endfunction

endpackage

// File: rtl/ipv4_arp_learn_if.sv
// Learn handshake, flush and LUT write-request bus of ipv4_arp_learn.
// master drives bindings/ack (parser + LUT side), slave is the learn block.
interface ipv4_arp_learn_if
  import ipv4_arp_pkg::*;
#(
  parameter int unsigned MAC_WIDTH = 48,
  parameter int unsigned ROW_BITS  = 5
);
  logic                     i_learn_valid;
  logic                     o_learn_ready;
  logic [31:0]              i_learn_ipv4_addr;
  logic [MAC_WIDTH-1:0]     i_learn_eth_addr;
  logic                     i_flush;
  logic                     o_ipv4_arp_lut_wr_req;
  logic                     i_ipv4_arp_lut_wr_ack;
  logic [ROW_BITS-1:0]      o_ipv4_arp_lut_wr_addr;
  logic [LUT_WR_DATA_W-1:0] o_ipv4_arp_lut_wr_eth_addr;
  logic [31:0]              o_ipv4_arp_lut_wr_ipv4_addr;
  logic                     o_learn_err;

  modport slave (
    input  i_learn_valid, i_learn_ipv4_addr, i_learn_eth_addr, i_flush,
           i_ipv4_arp_lut_wr_ack,
    output o_learn_ready, o_ipv4_arp_lut_wr_req, o_ipv4_arp_lut_wr_addr,
           o_ipv4_arp_lut_wr_eth_addr, o_ipv4_arp_lut_wr_ipv4_addr, o_learn_err
  );

  modport master (
    output i_learn_valid, i_learn_ipv4_addr, i_learn_eth_addr, i_flush,
           i_ipv4_arp_lut_wr_ack,
    input  o_learn_ready, o_ipv4_arp_lut_wr_req, o_ipv4_arp_lut_wr_addr,
           o_ipv4_arp_lut_wr_eth_addr, o_ipv4_arp_lut_wr_ipv4_addr, o_learn_err
  );

endinterface

// File: rtl/ipv4_arp_learn_match.sv
// Half-table comparator: first (lowest) valid row matching the key and the
// first invalid row within one half of the shadow table.
module ipv4_arp_learn_match #(
  parameter int unsigned HALF      = 16,
  parameter int unsigned IDX_BITS  = 4,
  parameter int unsigned MAC_WIDTH = 48
) (
  input  logic [HALF-1:0]                i_vld,
  input  logic [HALF-1:0][31:0]          i_ip,
  input  logic [HALF-1:0][MAC_WIDTH-1:0] i_mac,
  input  logic [31:0]                    i_key_ip,
  input  logic [MAC_WIDTH-1:0]           i_key_mac,
  output logic                           o_hit,
  output logic [IDX_BITS-1:0]            o_hit_idx,
  output logic                           o_same_mac,
  output logic                           o_free,
  output logic [IDX_BITS-1:0]            o_free_idx
);

  logic                w_hit;
  logic [IDX_BITS-1:0] w_hit_idx;
  logic                w_same;
  logic                w_free;
  logic [IDX_BITS-1:0] w_free_idx;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_same     = 1'b0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      if (!w_hit && i_vld[i] && (i_ip[i] == i_key_ip)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_BITS'(i);
        w_same    = (i_mac[i] == i_key_mac);
      end
      if (!w_free && !i_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_BITS'(i);
      end
    end
  end

  assign o_hit      = w_hit;
  assign o_hit_idx  = w_hit_idx;
  assign o_same_mac = w_same;
  assign o_free     = w_free;
  assign o_free_idx = w_free_idx;

endmodule

// File: rtl/ipv4_arp_learn.sv
// ARP LUT table writer with shadow copy, row reuse / lowest-free / round-robin
// eviction. Define IPV4_ARP_LEARN_STATS_EN to add event counters.
module ipv4_arp_learn
  import ipv4_arp_pkg::*;
#(
  parameter int unsigned IPV4_ARP_LUT_ROWS     = 32,
  parameter int unsigned IPV4_ARP_LUT_ROW_BITS = 5,
  parameter int unsigned MAC_WIDTH             = 48,
  parameter int unsigned ACK_TIMEOUT           = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  ipv4_arp_learn_if.slave       bus
`ifdef IPV4_ARP_LEARN_STATS_EN
  ,
  output logic [31:0]           o_stat_new,
  output logic [31:0]           o_stat_update,
  output logic [31:0]           o_stat_refresh,
  output logic [31:0]           o_stat_evict,
  output logic [31:0]           o_stat_drop,
  output logic [31:0]           o_stat_timeout
`endif
);

  localparam int unsigned ROWS = IPV4_ARP_LUT_ROWS;
  localparam int unsigned RB   = IPV4_ARP_LUT_ROW_BITS;
  localparam int unsigned HALF = ROWS / 2;
  localparam int unsigned IB   = RB - 1;

  learn_state_t                  r_state;
  logic                          r_ready, r_err, r_wr_req, r_flush_pend;
  logic [RB-1:0]                 r_wr_addr, r_rr;
  logic [LUT_WR_DATA_W-1:0]      r_wr_eth;
  logic [31:0]                   r_wr_ip, r_key_ip;
  logic [MAC_WIDTH-1:0]          r_key_mac;
  logic [7:0]                    r_cnt;
  logic                          r_evict, r_upd;
  logic [ROWS-1:0]               r_vld;
  logic [ROWS-1:0][31:0]         r_ip;
  logic [ROWS-1:0][MAC_WIDTH-1:0] r_mac;
  logic                          r_lo_hit, r_lo_same, r_lo_free;
  logic [IB-1:0]                 r_lo_idx, r_lo_free_idx;

  logic [HALF-1:0]                w_sel_vld;
  logic [HALF-1:0][31:0]          w_sel_ip;
  logic [HALF-1:0][MAC_WIDTH-1:0] w_sel_mac;
  logic                           w_hit, w_same, w_free;
  logic [IB-1:0]                  w_hit_idx, w_free_idx;
  logic                           w_hit_any, w_same_any, w_free_any;
  logic [RB-1:0]                  w_hit_row, w_free_row;

  // One comparator shared by both search states; the half is picked by state
  always_comb begin
    w_sel_vld = r_vld[HALF-1:0];
    w_sel_ip  = r_ip[HALF-1:0];
    w_sel_mac = r_mac[HALF-1:0];
    if (r_state == ST_SEARCH_HI) begin
      w_sel_vld = r_vld[ROWS-1:HALF];
      w_sel_ip  = r_ip[ROWS-1:HALF];
      w_sel_mac = r_mac[ROWS-1:HALF];
    end
  end

  ipv4_arp_learn_match #(.HALF(HALF), .IDX_BITS(IB), .MAC_WIDTH(MAC_WIDTH)) u_match (
    .i_vld      (w_sel_vld),
    .i_ip       (w_sel_ip),
    .i_mac      (w_sel_mac),
    .i_key_ip   (r_key_ip),
    .i_key_mac  (r_key_mac),
    .o_hit      (w_hit),
    .o_hit_idx  (w_hit_idx),
    .o_same_mac (w_same),
    .o_free     (w_free),
    .o_free_idx (w_free_idx)
  );

  always_comb begin
    w_hit_any  = r_lo_hit | w_hit;
    w_hit_row  = r_lo_hit ? {1'b0, r_lo_idx} : {1'b1, w_hit_idx};
    w_same_any = r_lo_hit ? r_lo_same : w_same;
    w_free_any = r_lo_free | w_free;
    w_free_row = r_lo_free ? {1'b0, r_lo_free_idx} : {1'b1, w_free_idx};
  end

`ifdef IPV4_ARP_LEARN_STATS_EN
  logic [31:0] r_st_new, r_st_upd, r_st_ref, r_st_evi, r_st_drop, r_st_to;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_ready       <= 1'b1;
      r_err         <= 1'b0;
      r_wr_req      <= 1'b0;
      r_flush_pend  <= 1'b0;
      r_wr_addr     <= '0;
      r_rr          <= '0;
      r_wr_eth      <= '0;
      r_wr_ip       <= '0;
      r_key_ip      <= '0;
      r_key_mac     <= '0;
      r_cnt         <= '0;
      r_evict       <= 1'b0;
      r_upd         <= 1'b0;
      r_vld         <= '0;
      r_lo_hit      <= 1'b0;
      r_lo_same     <= 1'b0;
      r_lo_free     <= 1'b0;
      r_lo_idx      <= '0;
      r_lo_free_idx <= '0;
`ifdef IPV4_ARP_LEARN_STATS_EN
      r_st_new <= '0; r_st_upd <= '0; r_st_ref <= '0;
      r_st_evi <= '0; r_st_drop <= '0; r_st_to <= '0;
`endif
    end else begin
      r_err    <= 1'b0;
      r_wr_req <= 1'b0;
      if (bus.i_flush && (r_state != ST_IDLE)) r_flush_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          // A pending flush lands in the first IDLE cycle, before any search
          if (bus.i_flush || r_flush_pend) begin
            r_vld        <= '0;
            r_rr         <= '0;
            r_flush_pend <= 1'b0;
          end
          if (bus.i_learn_valid) begin
            if (learn_drop(bus.i_learn_ipv4_addr, bus.i_learn_eth_addr)) begin
`ifdef IPV4_ARP_LEARN_STATS_EN
              r_st_drop <= r_st_drop + 32'd1;
`endif
            end else begin
              r_key_ip  <= bus.i_learn_ipv4_addr;
              r_key_mac <= bus.i_learn_eth_addr;
              r_ready   <= 1'b0;
              r_state   <= ST_SEARCH_LO;
            end
          end
        end
        ST_SEARCH_LO: begin
          r_lo_hit      <= w_hit;
          r_lo_idx      <= w_hit_idx;
          r_lo_same     <= w_same;
          r_lo_free     <= w_free;
          r_lo_free_idx <= w_free_idx;
          r_state       <= ST_SEARCH_HI;
        end
        ST_SEARCH_HI: begin
          if (w_hit_any && w_same_any) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
`ifdef IPV4_ARP_LEARN_STATS_EN
            r_st_ref <= r_st_ref + 32'd1;
`endif
          end else begin
            r_wr_addr <= w_hit_any ? w_hit_row : (w_free_any ? w_free_row : r_rr);
            r_upd     <= w_hit_any;
            r_evict   <= !w_hit_any && !w_free_any;
            r_wr_ip   <= r_key_ip;
            r_wr_eth  <= LUT_WR_DATA_W'(r_key_mac);
            r_wr_req  <= 1'b1;
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bus.i_ipv4_arp_lut_wr_ack) begin
            r_vld[r_wr_addr] <= 1'b1;
            if (r_evict) r_rr <= r_rr + 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
`ifdef IPV4_ARP_LEARN_STATS_EN
            if (r_evict)    r_st_evi <= r_st_evi + 32'd1;
            else if (r_upd) r_st_upd <= r_st_upd + 32'd1;
            else            r_st_new <= r_st_new + 32'd1;
`endif
          end else if (r_cnt == 8'(ACK_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
`ifdef IPV4_ARP_LEARN_STATS_EN
            r_st_to <= r_st_to + 32'd1;
`endif
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == ST_WAIT_ACK) && bus.i_ipv4_arp_lut_wr_ack) begin
      r_ip[r_wr_addr]  <= r_wr_ip;
      r_mac[r_wr_addr] <= r_wr_eth[MAC_WIDTH-1:0];
    end
  end

  assign bus.o_learn_ready               = r_ready;
  assign bus.o_ipv4_arp_lut_wr_req       = r_wr_req;
  assign bus.o_ipv4_arp_lut_wr_addr      = r_wr_addr;
  assign bus.o_ipv4_arp_lut_wr_eth_addr  = r_wr_eth;
  assign bus.o_ipv4_arp_lut_wr_ipv4_addr = r_wr_ip;
  assign bus.o_learn_err                 = r_err;

`ifdef IPV4_ARP_LEARN_STATS_EN
  assign o_stat_new     = r_st_new;
  assign o_stat_update  = r_st_upd;
  assign o_stat_refresh = r_st_ref;
  assign o_stat_evict   = r_st_evi;
  assign o_stat_drop    = r_st_drop;
  assign o_stat_timeout = r_st_to;
`endif

endmodule

// File: tb/tb_ipv4_arp_learn.sv
// Directed bench for ipv4_arp_learn with a 1-cycle-ack LUT responder.
`timescale 1ns/1ps
module tb_ipv4_arp_learn;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ipv4_arp_learn_if #(.MAC_WIDTH(48), .ROW_BITS(5)) bus ();

`ifdef IPV4_ARP_LEARN_STATS_EN
  logic [31:0] st_new, st_upd, st_ref, st_evi, st_drop, st_to;
`endif

  ipv4_arp_learn #(
    .IPV4_ARP_LUT_ROWS(32), .IPV4_ARP_LUT_ROW_BITS(5), .MAC_WIDTH(48), .ACK_TIMEOUT(15)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef IPV4_ARP_LEARN_STATS_EN
    ,
    .o_stat_new     (st_new),
    .o_stat_update  (st_upd),
    .o_stat_refresh (st_ref),
    .o_stat_evict   (st_evi),
    .o_stat_drop    (st_drop),
    .o_stat_timeout (st_to)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // LUT responder: ack during the cycle after the request cycle
  logic ack_en = 1'b1, ack_force = 1'b0, ack_resp = 1'b0, req_seen = 1'b0;
  int   req_cnt = 0, err_cnt = 0;
  logic [4:0]  last_addr = '0;
  logic [63:0] last_eth  = '0;
  assign bus.i_ipv4_arp_lut_wr_ack = ack_resp | ack_force;

  initial forever begin
    @(negedge clk);
    ack_resp = ack_en && req_seen;
    req_seen = bus.o_ipv4_arp_lut_wr_req;
    if (bus.o_ipv4_arp_lut_wr_req) begin
      req_cnt++;
      last_addr = bus.o_ipv4_arp_lut_wr_addr;
      last_eth  = bus.o_ipv4_arp_lut_wr_eth_addr;
    end
    if (bus.o_learn_err) err_cnt++;
  end

  // Offer one binding; lat = cycle index after acceptance at which ready is high
  task automatic learn(input logic [31:0] ip, input logic [47:0] mac, output int lat);
    @(negedge clk);
    bus.i_learn_valid = 1'b1;
    bus.i_learn_ipv4_addr = ip;
    bus.i_learn_eth_addr = mac;
    @(negedge clk);
    bus.i_learn_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.o_learn_ready) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic learn_write(input string tag, input logic [31:0] ip, input logic [47:0] mac,
                             input logic [4:0] row);
    int lat, r0;
    r0 = req_cnt;
    learn(ip, mac, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd5);
    chk({tag, "_row"}, 64'(last_addr), 64'(row));
    chk({tag, "_nreq"}, 64'(req_cnt - r0), 64'd1);
  endtask

  task automatic learn_nowrite(input string tag, input logic [31:0] ip, input logic [47:0] mac,
                               input int exp_lat);
    int lat, r0;
    r0 = req_cnt;
    learn(ip, mac, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_nreq"}, 64'(req_cnt - r0), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus.o_learn_ready), 64'd1);
    chk({tag, "_req"},   64'(bus.o_ipv4_arp_lut_wr_req), 64'd0);
    chk({tag, "_addr"},  64'(bus.o_ipv4_arp_lut_wr_addr), 64'd0);
    chk({tag, "_eth"},   bus.o_ipv4_arp_lut_wr_eth_addr, 64'd0);
    chk({tag, "_ip"},    64'(bus.o_ipv4_arp_lut_wr_ipv4_addr), 64'd0);
    chk({tag, "_err"},   64'(bus.o_learn_err), 64'd0);
  endtask

  initial begin
    int lat, r0, e0;
    bus.i_learn_valid = 1'b0;
    bus.i_learn_ipv4_addr = '0;
    bus.i_learn_eth_addr = '0;
    bus.i_flush = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    @(negedge clk);

    // First binding into an empty table
    learn_write("first", 32'h0a000001, 48'h001122334455, 5'd0);
    chk("first_eth", last_eth, 64'h0000001122334455);
    chk("first_ip", 64'(bus.o_ipv4_arp_lut_wr_ipv4_addr), 64'h0a000001);
    learn_write("upd", 32'h0a000001, 48'h001122334466, 5'd0);
    chk("upd_eth", last_eth, 64'h0000001122334466);
    learn_nowrite("refresh", 32'h0a000001, 48'h001122334466, 3);

    // Fill rows 1..31, then round-robin eviction including the 31->0 wrap
    for (int i = 1; i < 32; i++)
      learn_write("fill", 32'h0a000001 + 32'(i), 48'h020000000000 | 48'(i), 5'(i));
    for (int i = 0; i < 32; i++)
      learn_write("evict", 32'h0a000100 + 32'(i), 48'h040000000000 | 48'(i), 5'(i));
    learn_write("evict_wrap", 32'h0a000120, 48'h060000000001, 5'd0);

    // Drop filter
    learn_nowrite("drop_ip0", 32'h00000000, 48'h001122334455, 1);
    learn_nowrite("drop_grp", 32'h0a000002, 48'h01005e000001, 1);
    learn_nowrite("drop_mac0", 32'h0a000002, 48'h000000000000, 1);
`ifdef IPV4_ARP_LEARN_STATS_EN
    chk("st_new", 64'(st_new), 64'd32);
    chk("st_upd", 64'(st_upd), 64'd1);
    chk("st_ref", 64'(st_ref), 64'd1);
    chk("st_evi", 64'(st_evi), 64'd33);
    chk("st_drop", 64'(st_drop), 64'd3);
`endif

    // Idle flush, then ack timeout on the next free row
    @(negedge clk); bus.i_flush = 1'b1;
    @(negedge clk); bus.i_flush = 1'b0;
    learn_write("post_flush", 32'h0a000201, 48'h0a0000000001, 5'd0);
    ack_en = 1'b0;
    r0 = req_cnt; e0 = err_cnt;
    learn(32'h0a000202, 48'h0a0000000002, lat);
    chk("to_lat", 64'(lat), 64'd19);
    chk("to_err_now", 64'(bus.o_learn_err), 64'd1);
    chk("to_nreq", 64'(req_cnt - r0), 64'd1);
    chk("to_row", 64'(last_addr), 64'd1);
    @(negedge clk); #1;
    chk("to_err_cnt", 64'(err_cnt - e0), 64'd1);
    ack_en = 1'b1;
    learn_write("to_retry", 32'h0a000202, 48'h0a0000000002, 5'd1);
`ifdef IPV4_ARP_LEARN_STATS_EN
    chk("st_to", 64'(st_to), 64'd1);
`endif

    // Flush latched during WAIT_ACK, ack delivered by hand afterwards
    ack_en = 1'b0;
    @(negedge clk);
    bus.i_learn_valid = 1'b1;
    bus.i_learn_ipv4_addr = 32'h0a000301;
    bus.i_learn_eth_addr = 48'h0a0000000003;
    @(negedge clk); bus.i_learn_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fw_req", 64'(bus.o_ipv4_arp_lut_wr_req), 64'd1);
    @(negedge clk); bus.i_flush = 1'b1;
    @(negedge clk); bus.i_flush = 1'b0; ack_force = 1'b1;
    @(negedge clk); ack_force = 1'b0;
    #1;
    chk("fw_ready", 64'(bus.o_learn_ready), 64'd1);
    chk("fw_row", 64'(last_addr), 64'd2);
    ack_en = 1'b1;
    learn_write("fw_relearn0", 32'h0a000201, 48'h0a0000000001, 5'd0);
    learn_write("fw_relearn1", 32'h0a000301, 48'h0a0000000003, 5'd1);

    // Asynchronous reset while the write strobe is high
    ack_en = 1'b0;
    @(negedge clk);
    bus.i_learn_valid = 1'b1;
    bus.i_learn_ipv4_addr = 32'h0a000401;
    bus.i_learn_eth_addr = 48'h0a0000000004;
    @(negedge clk); bus.i_learn_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_req_before", 64'(bus.o_ipv4_arp_lut_wr_req), 64'd1);
    #1 resetn = 1'b0;
    #1 check_reset_outputs("ar");
    @(negedge clk); resetn = 1'b1;
    ack_en = 1'b1;
    learn_write("ar_after", 32'h0a000401, 48'h0a0000000004, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ipv4_arp_learn.md
# ipv4_arp_learn

Table writer for the IPv4 ARP LUT: accepts learned (IPv4, MAC) bindings from the ARP receive path and installs each into a table row. It reuses the row of an existing entry, otherwise takes the lowest free row, otherwise evicts round-robin. It drives the LUT write request/ack port and keeps a shadow copy of the table contents and row-valid bits so it never needs the LUT read port. It sits between the ARP packet parser and the write side of `ipv4_arp_lut`.

## Interface
- `IPV4_ARP_LUT_ROWS`, 32, table depth; must equal the LUT instance.
- `IPV4_ARP_LUT_ROW_BITS`, 5, log2 of rows.
- `MAC_WIDTH`, 48, ethernet address width.
- `ACK_TIMEOUT`, 15, cycles to wait for write ack before abort, 1..255.
- `clk` in 1: single clock. The LUT write port is clocked from this clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_learn_valid` in 1: binding offered.
- `o_learn_ready` out 1: block idle and can accept.
- `i_learn_ipv4_addr` in 32: sender protocol address.
- `i_learn_eth_addr` in MAC_WIDTH: sender hardware address.
- `i_flush` in 1: single-cycle pulse; invalidate all shadow rows.
- `o_ipv4_arp_lut_wr_req` out 1: one-cycle write strobe.
- `i_ipv4_arp_lut_wr_ack` in 1: write acknowledged.
- `o_ipv4_arp_lut_wr_addr` out ROW_BITS: target row.
- `o_ipv4_arp_lut_wr_eth_addr` out 64: `{16'h0, mac}`.
- `o_ipv4_arp_lut_wr_ipv4_addr` out 32: IPv4 key.
- `o_learn_err` out 1: one-cycle pulse on ack timeout.

## Operation
- States: IDLE, SEARCH_LO, SEARCH_HI, WRITE, WAIT_ACK.
- IDLE: `o_learn_ready`=1. Handshake completes on `i_learn_valid && o_learn_ready`; the operands are registered.
- Drop filter, applied at acceptance: IPv4 0.0.0.0, or MAC with group bit (bit 40) set, or MAC all-zero. A dropped binding stays in IDLE with no write.
- SEARCH_LO compares the shadow rows 0..ROWS/2-1; SEARCH_HI compares the upper half. The first match wins (lowest index).
- Row choice after SEARCH_HI:
  - Match with identical MAC → refresh only, no write, back to IDLE.
  - Match with different MAC → update that row.
  - No match → lowest invalid row.
  - No match and all rows valid → row `rr_ptr`; then `rr_ptr` increments, wrapping from ROWS-1 to 0.
- WRITE: assert `wr_req` for exactly one cycle with the address and data stable. The data stays stable until the state leaves WAIT_ACK.
- WAIT_ACK: on ack, update the shadow row and set its valid bit, then go to IDLE. If `ACK_TIMEOUT` cycles pass without ack, pulse `o_learn_err`, leave the shadow unchanged, and go to IDLE. `rr_ptr` is not advanced on a timeout.
- Flush:
  - Applied immediately if IDLE.
  - Otherwise latched as pending and applied on the next entry to IDLE; a latched flush clears the just-written row too.
  - Flush and a learn handshake in the same IDLE cycle: flush is applied first, then the learn proceeds against the empty shadow.
  - Flush resets `rr_ptr` to 0.
  - Flush does not write the LUT; stale LUT rows are overwritten on reuse.
- A stray ack outside WAIT_ACK is ignored.

## Timing
- Reset values:
  - `o_learn_ready`=1, all wr_* outputs 0, `o_learn_err`=0.
  - Shadow valid bits clear, `rr_ptr`=0, flush-pending 0, state IDLE.
- Reset mid-operation aborts immediately. A pending `wr_req` is deasserted asynchronously.
- Accept at edge T, then:
  - SEARCH_LO during T+1, SEARCH_HI during T+2.
  - `wr_req` high during T+3.
  - With the LUT's 1-cycle ack, ack arrives during T+4 and `o_learn_ready` is high during T+5.
- Refresh or drop: ready again at T+3 (refresh) or T+1 (drop).
- Timeout: `o_learn_err` is high in the cycle after the ACK_TIMEOUT-th waiting cycle.

## Configuration
- `IPV4_ARP_LEARN_STATS_EN` defined adds 32-bit wrap-around output counters, all reset to 0 and cleared only by reset: `o_stat_new`, `o_stat_update`, `o_stat_refresh`, `o_stat_evict`, `o_stat_drop`, `o_stat_timeout`.
  - Each counter increments once per corresponding event.
  - An eviction counts as evict, not new.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `ipv4_arp_pkg`: state encoding, the drop-filter function, the MAC group-bit index, and the LUT write-data width (64).
- One sub-module, `ipv4_arp_learn_match`: half-table comparator taking the shadow slice and key. It returns hit, hit index, same-MAC flag, first-free-row flag and its index. It is instantiated per half, or muxed across the two search states.

## Test plan
- Empty table, learn 10.0.0.1/00:11:22:33:44:55 → write row 0, `wr_eth_addr`=0x0000001122334455, ready high at T+5.
- Relearn 10.0.0.1 with 00:11:22:33:44:66 → write row 0 again; relearn with the same MAC → no `wr_req`, ready at T+3.
- Fill 32 distinct IPs, then learn 10.0.1.0 → write row 0; next new IP → row 1 (`rr_ptr` wrap at 31→0 also checked).
- Learn 0.0.0.0 or MAC 01:00:5e:00:00:01 → no `wr_req`, ready next cycle, drop counter +1 with STATS_EN.
- Ack held low → exactly one `wr_req` pulse, `o_learn_err` after 15 cycles, the next learn of the same IP targets the same free row.
- Flush during WAIT_ACK → after ack all rows invalid; the next new IP writes row 0. `resetn` low mid-WAIT_ACK → outputs return to reset values asynchronously.
